// File: rtl/ccff_bitstream_loader_if.sv
// Byte-wide configuration handshake between the bitstream source and the loader.
interface ccff_bitstream_loader_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serialises configuration bytes MSB-first into the ccff chain head and packs
// the bits leaving the chain tail back into readback bytes.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 80,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                          prog_clk,
  input  logic                          prog_reset,
  input  logic                          start,
  ccff_bitstream_loader_if.slave        cfg,
  output logic                          ccff_head,
  output logic                          ccff_shift_en,
  input  logic                          ccff_tail,
  output logic [7:0]                    rb_data,
  output logic                          rb_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int CMP_W = (CNT_W > 4) ? CNT_W : 4;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] bits_rem_r, bits_rem_nxt_s;
  logic [3:0]       byte_bits_r, byte_bits_nxt_s;
  logic [7:0]       buf_r, buf_nxt_s;
  logic [7:0]       rb_acc_r, rb_acc_nxt_s;
  logic [3:0]       rb_cnt_r, rb_cnt_nxt_s;
  logic [7:0]       rb_data_r, rb_data_nxt_s;
  logic             rb_valid_r, rb_valid_nxt_s;
  logic             done_r, done_nxt_s;

  logic             shift_s, ready_s, accept_s;
  logic [CMP_W-1:0] rem_w_s, bb_w_s, avail_s;
  logic [7:0]       tail_bit_s, rb_word_s;

  // State register with synchronous reset.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_r     <= IDLE;
      bits_rem_r  <= '0;
      byte_bits_r <= 4'd0;
      buf_r       <= 8'h00;
      rb_acc_r    <= 8'h00;
      rb_cnt_r    <= 4'd0;
      rb_data_r   <= 8'h00;
      rb_valid_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      bits_rem_r  <= bits_rem_nxt_s;
      byte_bits_r <= byte_bits_nxt_s;
      buf_r       <= buf_nxt_s;
      rb_acc_r    <= rb_acc_nxt_s;
      rb_cnt_r    <= rb_cnt_nxt_s;
      rb_data_r   <= rb_data_nxt_s;
      rb_valid_r  <= rb_valid_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  // Next-state, byte buffer and readback packing.
  always_comb begin
    rem_w_s    = CMP_W'(bits_rem_r);
    bb_w_s     = CMP_W'(byte_bits_r);
    shift_s    = (state_r == LOAD) && (byte_bits_r != 4'd0);
    // Refill while the last buffered bit is still shifting so bytes stream without a bubble.
    ready_s    = (state_r == LOAD) && (byte_bits_r <= 4'd1) && (rem_w_s > bb_w_s);
    accept_s   = ready_s && cfg.cfg_valid;
    avail_s    = (byte_bits_r == 4'd1) ? (rem_w_s - CMP_W'(1)) : rem_w_s;
    tail_bit_s = {7'd0, ccff_tail} << (3'd7 - rb_cnt_r[2:0]);
    rb_word_s  = rb_acc_r | tail_bit_s;

    state_nxt_s     = state_r;
    bits_rem_nxt_s  = bits_rem_r;
    byte_bits_nxt_s = byte_bits_r;
    buf_nxt_s       = buf_r;
    rb_acc_nxt_s    = rb_acc_r;
    rb_cnt_nxt_s    = rb_cnt_r;
    rb_data_nxt_s   = rb_data_r;
    rb_valid_nxt_s  = 1'b0;
    done_nxt_s      = done_r;

    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s     = LOAD;
          done_nxt_s      = 1'b0;
          bits_rem_nxt_s  = CNT_W'(CHAIN_LEN);
          byte_bits_nxt_s = 4'd0;
          buf_nxt_s       = 8'h00;
          rb_acc_nxt_s    = 8'h00;
          rb_cnt_nxt_s    = 4'd0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      LOAD: begin
        if (shift_s) begin
          buf_nxt_s       = {buf_r[6:0], 1'b0};
          byte_bits_nxt_s = byte_bits_r - 4'd1;
          bits_rem_nxt_s  = bits_rem_r - CNT_W'(1);
          if ((rb_cnt_r == 4'd7) || (bits_rem_r == CNT_W'(1))) begin
            rb_data_nxt_s  = rb_word_s;
            rb_valid_nxt_s = 1'b1;
            rb_acc_nxt_s   = 8'h00;
            rb_cnt_nxt_s   = 4'd0;
          end else begin
            rb_acc_nxt_s   = rb_word_s;
            rb_cnt_nxt_s   = rb_cnt_r + 4'd1;
          end
          if (bits_rem_r == CNT_W'(1)) begin
            state_nxt_s = DONE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = LOAD;
          end
        end else begin
          state_nxt_s = LOAD;
        end
        // A short final byte keeps only its top bits; the rest never reach the chain.
        if (accept_s) begin
          buf_nxt_s       = cfg.cfg_data;
          byte_bits_nxt_s = (avail_s >= CMP_W'(8)) ? 4'd8 : avail_s[3:0];
        end else begin
          buf_nxt_s = buf_nxt_s;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign cfg.cfg_ready   = ready_s;
  assign ccff_shift_en   = shift_s;
  assign ccff_head       = shift_s & buf_r[7];
  assign rb_data         = rb_data_r;
  assign rb_valid        = rb_valid_r;
  assign busy            = (state_r == LOAD);
  assign done            = done_r;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Randomised bench for two loader instances (16- and 12-bit chains) against a
// bitstream-level model and a behavioural chain shift register.
module tb_ccff_bitstream_loader;
  localparam int L0 = 16;
  localparam int L1 = 12;

  logic            prog_clk   = 1'b0;
  logic            prog_reset = 1'b1;
  logic [1:0]      start      = 2'b00;
  logic [1:0]      valid_d    = 2'b00;
  logic [1:0]      pre_req    = 2'b00;
  logic [1:0][7:0] data_d     = '0;
  logic [15:0]     pre_val    = 16'h0000;
  logic [1:0]      ready_o, head_o, shen_o, rbv_o, busy_o, done_o;
  logic [1:0][7:0] rbd_o;
  logic [15:0]     chain0 = 16'h0000;
  logic [15:0]     chain1 = 16'h0000;
  logic [7:0]      offer_q[$];
  int              total = 0;
  int              bad   = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader_if if0 ();
  ccff_bitstream_loader_if if1 ();
  assign if0.cfg_data  = data_d[0];
  assign if0.cfg_valid = valid_d[0];
  assign ready_o[0]    = if0.cfg_ready;
  assign if1.cfg_data  = data_d[1];
  assign if1.cfg_valid = valid_d[1];
  assign ready_o[1]    = if1.cfg_ready;

  ccff_bitstream_loader #(.CHAIN_LEN(L0)) dut0 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start[0]), .cfg(if0.slave),
    .ccff_head(head_o[0]), .ccff_shift_en(shen_o[0]), .ccff_tail(chain0[L0-1]),
    .rb_data(rbd_o[0]), .rb_valid(rbv_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  ccff_bitstream_loader #(.CHAIN_LEN(L1)) dut1 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start[1]), .cfg(if1.slave),
    .ccff_head(head_o[1]), .ccff_shift_en(shen_o[1]), .ccff_tail(chain1[L1-1]),
    .rb_data(rbd_o[1]), .rb_valid(rbv_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  // Behavioural configuration chains: head enters position 0, tail is position LEN-1.
  always @(posedge prog_clk) begin
    if (pre_req[0]) chain0 <= pre_val;
    else if (shen_o[0]) chain0 <= {chain0[14:0], head_o[0]};
    if (pre_req[1]) chain1 <= pre_val;
    else if (shen_o[1]) chain1 <= {chain1[14:0], head_o[1]};
  end

  function automatic int len_of(input int u);
    return (u == 0) ? L0 : L1;
  endfunction

  function automatic logic [15:0] chain_of(input int u);
    return (u == 0) ? chain0 : chain1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_offers(input int u);
    offer_q.delete();
    for (int i = 0; i < (len_of(u) + 7) / 8 + 1; i++) offer_q.push_back(8'($urandom));
  endtask

  task automatic run_load(input int u, input int gap, input bit mid_start, input logic [15:0] pre);
    int L = len_of(u);
    int nb = (L + 7) / 8;
    int acc = 0, nshift = 0, first_shift = -1, last_shift = -1, first_done = -1;
    int idle_nz = 0, next_ok = 0;
    logic [31:0] got_head = 32'd0, exp_head = 32'd0;
    logic [15:0] mask;
    logic [7:0] bt, acc8;
    logic [7:0] rb_q[$];
    logic [7:0] exp_rb[$];

    // Expected image: the first L bits of the offered bitstream, MSB of each byte first.
    for (int i = 0; i < L; i++) begin
      bt = offer_q[i / 8];
      exp_head = {exp_head[30:0], bt[7 - (i % 8)]};
    end
    // Expected readback: bit k is chain position L-1-k, packed MSB-first, short byte left-justified.
    acc8 = 8'h00;
    for (int k = 0; k < L; k++) begin
      acc8[7 - (k % 8)] = pre[L - 1 - k];
      if ((k % 8 == 7) || (k == L - 1)) begin
        exp_rb.push_back(acc8);
        acc8 = 8'h00;
      end
    end
    mask = 16'((32'd1 << L) - 32'd1);

    @(negedge prog_clk);
    pre_val = pre;
    pre_req[u] = 1'b1;
    @(negedge prog_clk);
    pre_req[u] = 1'b0;
    start[u] = 1'b1;
    @(negedge prog_clk);
    start[u] = 1'b0;
    check_eq("busy_after_start", 32'(busy_o[u]), 32'd1);
    check_eq("done_clr_on_start", 32'(done_o[u]), 32'd0);

    for (int cyc = 0; cyc < 400; cyc++) begin
      valid_d[u] = (acc < offer_q.size()) && (cyc >= next_ok);
      data_d[u]  = (acc < offer_q.size()) ? offer_q[acc] : 8'h00;
      start[u]   = mid_start && (cyc == 5);
      #1;
      if (ready_o[u] && valid_d[u]) begin
        acc++;
        next_ok = cyc + gap;
      end
      if (shen_o[u]) begin
        got_head = {got_head[30:0], head_o[u]};
        nshift++;
        if (first_shift < 0) first_shift = cyc;
        last_shift = cyc;
      end else if (head_o[u]) begin
        idle_nz++;
      end
      if (rbv_o[u]) rb_q.push_back(rbd_o[u]);
      if (done_o[u] && first_done < 0) first_done = cyc;
      if (first_done >= 0 && cyc >= first_done + 4) break;
      @(negedge prog_clk);
    end
    valid_d[u] = 1'b0;
    start[u]   = 1'b0;

    check_eq("done_seen", 32'(first_done >= 0), 32'd1);
    check_eq("shift_count", 32'(nshift), 32'(L));
    check_eq("head_seq", got_head, exp_head);
    check_eq("head_idle_zero", 32'(idle_nz), 32'd0);
    check_eq("done_latency", 32'(first_done - last_shift), 32'd1);
    check_eq("bytes_accepted", 32'(acc), 32'(nb));
    if (gap == 0) check_eq("shift_contiguous", 32'(last_shift - first_shift + 1), 32'(L));
    check_eq("rb_strobes", 32'(rb_q.size()), 32'(nb));
    for (int i = 0; i < nb && i < rb_q.size(); i++) check_eq("rb_byte", 32'(rb_q[i]), 32'(exp_rb[i]));
    check_eq("chain_image", 32'(chain_of(u) & mask), exp_head);
    check_eq("busy_end", 32'(busy_o[u]), 32'd0);
    check_eq("done_sticky", 32'(done_o[u]), 32'd1);
  endtask

  task automatic reset_mid(input int u);
    int n = 0;
    int rbv_seen = 0;
    fill_offers(u);
    @(negedge prog_clk);
    start[u] = 1'b1;
    @(negedge prog_clk);
    start[u] = 1'b0;
    for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
      valid_d[u] = 1'b1;
      data_d[u]  = offer_q[0];
      #1;
      if (shen_o[u]) n++;
      @(negedge prog_clk);
    end
    valid_d[u] = 1'b0;
    check_eq("rst_shifts_before", 32'(n), 32'd5);
    prog_reset = 1'b1;
    @(negedge prog_clk);
    prog_reset = 1'b0;
    check_eq("rst_busy", 32'(busy_o[u]), 32'd0);
    check_eq("rst_shift_en", 32'(shen_o[u]), 32'd0);
    check_eq("rst_done", 32'(done_o[u]), 32'd0);
    check_eq("rst_ready", 32'(ready_o[u]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (rbv_o[u]) rbv_seen++;
      @(negedge prog_clk);
    end
    check_eq("rst_no_rb_valid", 32'(rbv_seen), 32'd0);
    fill_offers(u);
    run_load(u, 0, 1'b0, 16'($urandom));
  endtask

  initial begin
    repeat (3) @(negedge prog_clk);
    for (int u = 0; u < 2; u++) begin
      check_eq("reset_ready", 32'(ready_o[u]), 32'd0);
      check_eq("reset_head", 32'(head_o[u]), 32'd0);
      check_eq("reset_shift_en", 32'(shen_o[u]), 32'd0);
      check_eq("reset_rb_data", 32'(rbd_o[u]), 32'd0);
      check_eq("reset_rb_valid", 32'(rbv_o[u]), 32'd0);
      check_eq("reset_busy", 32'(busy_o[u]), 32'd0);
      check_eq("reset_done", 32'(done_o[u]), 32'd0);
    end
    prog_reset = 1'b0;

    offer_q = '{8'hA5, 8'h3C, 8'h5A};
    run_load(0, 0, 1'b0, 16'hF00F);
    offer_q = '{8'hFF, 8'hB7, 8'h11};
    run_load(1, 0, 1'b0, 16'h0ABC);
    offer_q = '{8'hA5, 8'h3C, 8'h5A};
    run_load(0, 20, 1'b0, 16'hF00F);
    fill_offers(0);
    run_load(0, 0, 1'b1, 16'($urandom));
    fill_offers(1);
    run_load(1, 20, 1'b1, 16'($urandom));
    reset_mid(0);
    reset_mid(1);

    for (int it = 0; it < 12; it++) begin
      int u = int'($urandom_range(1, 0));
      int sel = int'($urandom_range(3, 0));
      int gap = (sel == 0) ? 0 : (sel == 1) ? 3 : (sel == 2) ? 20 : 0;
      fill_offers(u);
      run_load(u, gap, 1'($urandom), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit");
  end

endmodule
